// File: rtl/rs_alu_pkg.sv
// Shared types and constants for the ALU reservation station.
//   - widths: RsSize entries, Xlen data, RobW ROB tag, OpW opcode
//   - operand_t / cdb_t / entry_t record types
//   - snoop(): resolves a pending operand against both CDB ports
package rs_alu_pkg;

  localparam int unsigned RsSize = 16;
  localparam int unsigned RsIdxW = $clog2(RsSize);
  localparam int unsigned Xlen   = 32;
  localparam int unsigned RobW   = 4;
  localparam int unsigned OpW    = 6;

  // Internal opcode codes (subset of the shared decoder encoding).
  localparam logic [OpW-1:0] OpAdd   = 6'd1;
  localparam logic [OpW-1:0] OpSub   = 6'd2;
  localparam logic [OpW-1:0] OpAuipc = 6'd3;
  localparam logic [OpW-1:0] OpJal   = 6'd4;

  typedef struct packed {
    logic            busy;  // value still pending on tag
    logic [RobW-1:0] tag;
    logic [Xlen-1:0] val;
  } operand_t;

  typedef struct packed {
    logic            valid;
    logic [RobW-1:0] tag;
    logic [Xlen-1:0] val;
  } cdb_t;

  typedef struct packed {
    logic            busy;
    logic [OpW-1:0]  op;
    logic [Xlen-1:0] pc;
    logic [Xlen-1:0] imm;
    logic [RobW-1:0] rob;
    operand_t        j;
    operand_t        k;
  } entry_t;

  // Capture a broadcast value for a pending operand. The ALU port wins if
  // both ports carry the same tag.
  function automatic operand_t snoop(operand_t opnd, cdb_t alu, cdb_t lsb);
    operand_t res;
    res = opnd;
    if (opnd.busy) begin
      if (alu.valid && alu.tag == opnd.tag) begin
        res.busy = 1'b0;
        res.val  = alu.val;
      end else if (lsb.valid && lsb.tag == opnd.tag) begin
        res.busy = 1'b0;
        res.val  = lsb.val;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_alu_sel.sv
// Lowest-index priority encoder.
//   req_i   : request vector
//   valid_o : any request set
//   idx_o   : index of the lowest set request (0 when none)
module rs_alu_sel
  import rs_alu_pkg::*;
#(
  parameter int unsigned Width = RsSize,
  parameter int unsigned IdxW  = $clog2(Width)
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdxW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station. Holds dispatched ALU ops until both operands are
// known, snoops both CDB ports for wakeup, issues one ready op per cycle.
//   clk_i, rst_ni (async, active-low), rdy_i (0 = stall), clear_i (flush)
//   disp_*_i  : dispatch request with operand tags/values
//   cdb_alu_*_i, cdb_lsb_*_i : result broadcasts
//   rs_full_o : all entries busy (from registered state)
//   iss_*_o   : registered issue strobe and payload to the ALU
module rs_alu
  import rs_alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rdy_i,
  input  logic            clear_i,
  input  logic            disp_valid_i,
  input  logic [OpW-1:0]  disp_opcode_i,
  input  logic [Xlen-1:0] disp_pc_i,
  input  logic [Xlen-1:0] disp_imm_i,
  input  logic [RobW-1:0] disp_rob_pos_i,
  input  logic            disp_qj_busy_i,
  input  logic [RobW-1:0] disp_qj_i,
  input  logic [Xlen-1:0] disp_vj_i,
  input  logic            disp_qk_busy_i,
  input  logic [RobW-1:0] disp_qk_i,
  input  logic [Xlen-1:0] disp_vk_i,
  input  logic            cdb_alu_valid_i,
  input  logic [RobW-1:0] cdb_alu_rob_pos_i,
  input  logic [Xlen-1:0] cdb_alu_val_i,
  input  logic            cdb_lsb_valid_i,
  input  logic [RobW-1:0] cdb_lsb_rob_pos_i,
  input  logic [Xlen-1:0] cdb_lsb_val_i,
  output logic            rs_full_o,
  output logic            iss_valid_o,
  output logic [OpW-1:0]  iss_opcode_o,
  output logic [Xlen-1:0] iss_pc_o,
  output logic [Xlen-1:0] iss_vj_o,
  output logic [Xlen-1:0] iss_vk_o,
  output logic [Xlen-1:0] iss_imm_o,
  output logic [RobW-1:0] iss_rob_pos_o
);

  entry_t ent_q [RsSize];
  entry_t ent_d [RsSize];

  logic            iss_valid_q, iss_valid_d;
  logic [OpW-1:0]  iss_opcode_q, iss_opcode_d;
  logic [Xlen-1:0] iss_pc_q, iss_pc_d;
  logic [Xlen-1:0] iss_vj_q, iss_vj_d;
  logic [Xlen-1:0] iss_vk_q, iss_vk_d;
  logic [Xlen-1:0] iss_imm_q, iss_imm_d;
  logic [RobW-1:0] iss_rob_q, iss_rob_d;

  logic [RsSize-1:0] busy_vec, ready_vec, free_vec;
  logic              free_valid, ready_valid;
  logic [RsIdxW-1:0] free_idx, ready_idx;

  cdb_t     cdb_alu, cdb_lsb;
  operand_t disp_j, disp_k;

  always_comb begin
    cdb_alu = '{valid: cdb_alu_valid_i, tag: cdb_alu_rob_pos_i, val: cdb_alu_val_i};
    cdb_lsb = '{valid: cdb_lsb_valid_i, tag: cdb_lsb_rob_pos_i, val: cdb_lsb_val_i};
    disp_j  = '{busy: disp_qj_busy_i, tag: disp_qj_i, val: disp_vj_i};
    disp_k  = '{busy: disp_qk_busy_i, tag: disp_qk_i, val: disp_vk_i};
  end

  // Ready and free are taken from registered state only, so a slot freed by
  // this cycle's issue is not visible to dispatch until the next cycle.
  always_comb begin
    for (int i = 0; i < RsSize; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].j.busy && !ent_q[i].k.busy;
    end
  end

  assign free_vec  = ~busy_vec;
  assign rs_full_o = &busy_vec;

  rs_alu_sel #(.Width(RsSize)) u_free_sel (
    .req_i   (free_vec),
    .valid_o (free_valid),
    .idx_o   (free_idx)
  );

  rs_alu_sel #(.Width(RsSize)) u_ready_sel (
    .req_i   (ready_vec),
    .valid_o (ready_valid),
    .idx_o   (ready_idx)
  );

  always_comb begin
    ent_d        = ent_q;
    iss_valid_d  = 1'b0;
    iss_opcode_d = iss_opcode_q;
    iss_pc_d     = iss_pc_q;
    iss_vj_d     = iss_vj_q;
    iss_vk_d     = iss_vk_q;
    iss_imm_d    = iss_imm_q;
    iss_rob_d    = iss_rob_q;

    if (clear_i) begin
      for (int i = 0; i < RsSize; i++) ent_d[i].busy = 1'b0;
    end else begin
      if (ready_valid) begin
        iss_valid_d           = 1'b1;
        iss_opcode_d          = ent_q[ready_idx].op;
        iss_pc_d              = ent_q[ready_idx].pc;
        iss_vj_d              = ent_q[ready_idx].j.val;
        iss_vk_d              = ent_q[ready_idx].k.val;
        iss_imm_d             = ent_q[ready_idx].imm;
        iss_rob_d             = ent_q[ready_idx].rob;
        ent_d[ready_idx].busy = 1'b0;
      end

      for (int i = 0; i < RsSize; i++) begin
        if (ent_q[i].busy) begin
          ent_d[i].j = snoop(ent_q[i].j, cdb_alu, cdb_lsb);
          ent_d[i].k = snoop(ent_q[i].k, cdb_alu, cdb_lsb);
        end
      end

      // free_valid is the complement of rs_full_o; a full station drops it.
      if (disp_valid_i && free_valid) begin
        ent_d[free_idx].busy = 1'b1;
        ent_d[free_idx].op   = disp_opcode_i;
        ent_d[free_idx].pc   = disp_pc_i;
        ent_d[free_idx].imm  = disp_imm_i;
        ent_d[free_idx].rob  = disp_rob_pos_i;
        ent_d[free_idx].j    = snoop(disp_j, cdb_alu, cdb_lsb);
        ent_d[free_idx].k    = snoop(disp_k, cdb_alu, cdb_lsb);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RsSize; i++) ent_q[i] <= '0;
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_pc_q     <= '0;
      iss_vj_q     <= '0;
      iss_vk_q     <= '0;
      iss_imm_q    <= '0;
      iss_rob_q    <= '0;
    end else if (rdy_i) begin
      ent_q        <= ent_d;
      iss_valid_q  <= iss_valid_d;
      iss_opcode_q <= iss_opcode_d;
      iss_pc_q     <= iss_pc_d;
      iss_vj_q     <= iss_vj_d;
      iss_vk_q     <= iss_vk_d;
      iss_imm_q    <= iss_imm_d;
      iss_rob_q    <= iss_rob_d;
    end else begin
      // Stalled: hold everything but never repeat the last issue.
      iss_valid_q <= 1'b0;
    end
  end

  assign iss_valid_o   = iss_valid_q;
  assign iss_opcode_o  = iss_opcode_q;
  assign iss_pc_o      = iss_pc_q;
  assign iss_vj_o      = iss_vj_q;
  assign iss_vk_o      = iss_vk_q;
  assign iss_imm_o     = iss_imm_q;
  assign iss_rob_pos_o = iss_rob_q;

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios followed by random
// traffic, all compared against a behavioural model of the station.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy, clear;
  logic        disp_valid;
  logic [5:0]  disp_opcode;
  logic [31:0] disp_pc, disp_imm, disp_vj, disp_vk;
  logic [3:0]  disp_rob_pos, disp_qj, disp_qk;
  logic        disp_qj_busy, disp_qk_busy;
  logic        cdb_a_v, cdb_l_v;
  logic [3:0]  cdb_a_tag, cdb_l_tag;
  logic [31:0] cdb_a_val, cdb_l_val;
  logic        rs_full, iss_valid;
  logic [5:0]  iss_opcode;
  logic [31:0] iss_pc, iss_vj, iss_vk, iss_imm;
  logic [3:0]  iss_rob_pos;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  rs_alu u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .rdy_i             (rdy),
    .clear_i           (clear),
    .disp_valid_i      (disp_valid),
    .disp_opcode_i     (disp_opcode),
    .disp_pc_i         (disp_pc),
    .disp_imm_i        (disp_imm),
    .disp_rob_pos_i    (disp_rob_pos),
    .disp_qj_busy_i    (disp_qj_busy),
    .disp_qj_i         (disp_qj),
    .disp_vj_i         (disp_vj),
    .disp_qk_busy_i    (disp_qk_busy),
    .disp_qk_i         (disp_qk),
    .disp_vk_i         (disp_vk),
    .cdb_alu_valid_i   (cdb_a_v),
    .cdb_alu_rob_pos_i (cdb_a_tag),
    .cdb_alu_val_i     (cdb_a_val),
    .cdb_lsb_valid_i   (cdb_l_v),
    .cdb_lsb_rob_pos_i (cdb_l_tag),
    .cdb_lsb_val_i     (cdb_l_val),
    .rs_full_o         (rs_full),
    .iss_valid_o       (iss_valid),
    .iss_opcode_o      (iss_opcode),
    .iss_pc_o          (iss_pc),
    .iss_vj_o          (iss_vj),
    .iss_vk_o          (iss_vk),
    .iss_imm_o         (iss_imm),
    .iss_rob_pos_o     (iss_rob_pos)
  );

  // ---------------- reference model ----------------
  bit          m_busy [16];
  bit          m_jw [16], m_kw [16];  // operand still waiting
  logic [5:0]  m_op [16];
  logic [31:0] m_pc [16], m_imm [16], m_vj [16], m_vk [16];
  logic [3:0]  m_rob [16], m_qj [16], m_qk [16];
  bit          e_valid;
  logic [5:0]  e_op;
  logic [31:0] e_pc, e_vj, e_vk, e_imm;
  logic [3:0]  e_rob;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    e_valid = 0; e_op = '0; e_pc = '0; e_vj = '0; e_vk = '0; e_imm = '0; e_rob = '0;
  endtask

  function automatic bit m_full();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n == 16;
  endfunction

  // Value broadcast this cycle for a tag; ALU port has precedence.
  function automatic bit hit(input logic [3:0] tag, output logic [31:0] v);
    v = '0;
    if (cdb_a_v && cdb_a_tag == tag) begin v = cdb_a_val; return 1'b1; end
    if (cdb_l_v && cdb_l_tag == tag) begin v = cdb_l_val; return 1'b1; end
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic m_step();
    int sel = -1;
    int slot = -1;
    bit was_full;
    logic [31:0] v;
    if (!rdy) begin e_valid = 0; return; end
    if (clear) begin m_reset_busy(); e_valid = 0; return; end
    was_full = m_full();
    for (int i = 0; i < 16; i++) begin
      if (!m_busy[i] && slot < 0) slot = i;
      if (m_busy[i] && !m_jw[i] && !m_kw[i] && sel < 0) sel = i;
    end
    e_valid = (sel >= 0);
    if (sel >= 0) begin
      e_op = m_op[sel]; e_pc = m_pc[sel]; e_vj = m_vj[sel]; e_vk = m_vk[sel];
      e_imm = m_imm[sel]; e_rob = m_rob[sel];
      m_busy[sel] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_busy[i]) begin
        if (m_jw[i] && hit(m_qj[i], v)) begin m_vj[i] = v; m_jw[i] = 0; end
        if (m_kw[i] && hit(m_qk[i], v)) begin m_vk[i] = v; m_kw[i] = 0; end
      end
    end
    if (disp_valid && !was_full) begin
      m_busy[slot] = 1; m_op[slot] = disp_opcode; m_pc[slot] = disp_pc;
      m_imm[slot] = disp_imm; m_rob[slot] = disp_rob_pos;
      m_jw[slot] = disp_qj_busy; m_qj[slot] = disp_qj; m_vj[slot] = disp_vj;
      m_kw[slot] = disp_qk_busy; m_qk[slot] = disp_qk; m_vk[slot] = disp_vk;
      if (disp_qj_busy && hit(disp_qj, v)) begin m_vj[slot] = v; m_jw[slot] = 0; end
      if (disp_qk_busy && hit(disp_qk, v)) begin m_vk[slot] = v; m_kw[slot] = 0; end
    end
  endtask

  task automatic m_reset_busy();
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rs_full", 64'(rs_full), 64'(m_full()));
    chk("iss_valid", 64'(iss_valid), 64'(e_valid));
    chk("iss_opcode", 64'(iss_opcode), 64'(e_op));
    chk("iss_pc", 64'(iss_pc), 64'(e_pc));
    chk("iss_vj", 64'(iss_vj), 64'(e_vj));
    chk("iss_vk", 64'(iss_vk), 64'(e_vk));
    chk("iss_imm", 64'(iss_imm), 64'(e_imm));
    chk("iss_rob_pos", 64'(iss_rob_pos), 64'(e_rob));
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rdy = 1; clear = 0; disp_valid = 0;
    disp_opcode = '0; disp_pc = '0; disp_imm = '0; disp_rob_pos = '0;
    disp_qj_busy = 0; disp_qj = '0; disp_vj = '0;
    disp_qk_busy = 0; disp_qk = '0; disp_vk = '0;
    cdb_a_v = 0; cdb_a_tag = '0; cdb_a_val = '0;
    cdb_l_v = 0; cdb_l_tag = '0; cdb_l_val = '0;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [3:0] rob,
                          input bit jb, input logic [3:0] qj, input logic [31:0] vj,
                          input bit kb, input logic [3:0] qk, input logic [31:0] vk);
    disp_valid = 1; disp_opcode = op; disp_rob_pos = rob;
    disp_pc = 32'h1000 + 32'(rob) * 4; disp_imm = 32'h100 + 32'(rob);
    disp_qj_busy = jb; disp_qj = qj; disp_vj = vj;
    disp_qk_busy = kb; disp_qk = qk; disp_vk = vk;
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // Ready ADD: issues one cycle after dispatch, strobe lasts one cycle.
    set_disp(OpAdd, 4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7);
    cycle();
    chk("add_lat0", 64'(iss_valid), 64'd0);
    idle(); cycle();
    chk("add_valid", 64'(iss_valid), 64'd1);
    chk("add_vj", 64'(iss_vj), 64'd5);
    chk("add_vk", 64'(iss_vk), 64'd7);
    chk("add_rob", 64'(iss_rob_pos), 64'd3);
    cycle();
    chk("add_once", 64'(iss_valid), 64'd0);

    // SUB waiting on tag 2, woken by ALU broadcast two cycles later.
    set_disp(OpSub, 4'd4, 1, 4'd2, 32'hDEAD, 0, 4'd0, 32'd1);
    cycle();
    idle(); cycle();
    cdb_a_v = 1; cdb_a_tag = 4'd2; cdb_a_val = 32'h10;
    cycle();
    chk("sub_wait", 64'(iss_valid), 64'd0);
    idle(); cycle();
    chk("sub_valid", 64'(iss_valid), 64'd1);
    chk("sub_vj", 64'(iss_vj), 64'h10);

    // Dispatch bypass from the load port.
    set_disp(OpAdd, 4'd7, 0, 4'd0, 32'd9, 1, 4'd6, 32'd0);
    cdb_l_v = 1; cdb_l_tag = 4'd6; cdb_l_val = 32'hAB;
    cycle();
    idle(); cycle();
    chk("byp_valid", 64'(iss_valid), 64'd1);
    chk("byp_vk", 64'(iss_vk), 64'hAB);

    // Fill all entries, each waiting on its own tag.
    for (int i = 0; i < 16; i++) begin
      set_disp(OpAdd, 4'(i), 1, 4'(i), 32'd0, 0, 4'd0, 32'(i));
      cycle();
    end
    chk("fill_full", 64'(rs_full), 64'd1);
    set_disp(OpJal, 4'd15, 0, 4'd0, 32'd1, 0, 4'd0, 32'd2);
    cycle();
    idle(); cycle();
    chk("drop_no_iss", 64'(iss_valid), 64'd0);
    cdb_a_v = 1; cdb_a_tag = 4'd5; cdb_a_val = 32'h55;
    cdb_l_v = 1; cdb_l_tag = 4'd9; cdb_l_val = 32'h99;
    cycle();
    idle(); cycle();
    chk("pair_first", 64'(iss_rob_pos), 64'd5);
    chk("pair_first_vj", 64'(iss_vj), 64'h55);
    cycle();
    chk("pair_second", 64'(iss_rob_pos), 64'd9);
    chk("pair_second_v", 64'(iss_valid), 64'd1);

    // Flush with dispatch and broadcast in the same cycle.
    set_disp(OpAdd, 4'd1, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    clear = 1; cdb_a_v = 1; cdb_a_tag = 4'd0; cdb_a_val = 32'h1;
    cycle();
    chk("clr_valid", 64'(iss_valid), 64'd0);
    chk("clr_full", 64'(rs_full), 64'd0);
    for (int t = 0; t < 16; t++) begin
      idle(); cdb_a_v = 1; cdb_a_tag = 4'(t); cdb_a_val = 32'(t);
      cycle();
      chk("clr_no_iss", 64'(iss_valid), 64'd0);
    end

    // Stall with a ready entry.
    set_disp(OpAuipc, 4'd2, 0, 4'd0, 32'd3, 0, 4'd0, 32'd4);
    cycle();
    idle(); rdy = 0;
    cycle();
    chk("stall0", 64'(iss_valid), 64'd0);
    cycle();
    chk("stall1", 64'(iss_valid), 64'd0);
    rdy = 1;
    cycle();
    chk("stall_rel", 64'(iss_valid), 64'd1);
    chk("stall_rob", 64'(iss_rob_pos), 64'd2);
    idle(); cycle();

    // Asynchronous reset with three waiting entries and an issue in flight.
    for (int i = 1; i <= 3; i++) begin
      set_disp(OpSub, 4'(i + 8), 1, 4'(i), 32'd0, 0, 4'd0, 32'd0);
      cycle();
    end
    set_disp(OpAdd, 4'd12, 0, 4'd0, 32'h77, 0, 4'd0, 32'h88);
    cycle();
    idle(); cycle();
    chk("pre_rst_valid", 64'(iss_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    m_reset();
    chk("rst_valid", 64'(iss_valid), 64'd0);
    chk("rst_full", 64'(rs_full), 64'd0);
    chk("rst_vj", 64'(iss_vj), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int t = 1; t <= 3; t++) begin
      idle(); cdb_a_v = 1; cdb_a_tag = 4'(t); cdb_a_val = 32'hF0;
      cycle();
      chk("rst_gone", 64'(iss_valid), 64'd0);
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rdy          = ($urandom_range(0, 9) != 0);
      clear        = ($urandom_range(0, 63) == 0);
      disp_valid   = ($urandom_range(0, 9) < 4);
      disp_opcode  = 6'($urandom);
      disp_pc      = $urandom;
      disp_imm     = $urandom;
      disp_rob_pos = 4'($urandom);
      disp_qj_busy = 1'($urandom);
      disp_qj      = 4'($urandom);
      disp_vj      = $urandom;
      disp_qk_busy = 1'($urandom);
      disp_qk      = 4'($urandom);
      disp_vk      = $urandom;
      cdb_a_v      = ($urandom_range(0, 99) < 35);
      cdb_a_tag    = 4'($urandom);
      cdb_a_val    = $urandom;
      cdb_l_v      = ($urandom_range(0, 99) < 35);
      cdb_l_tag    = 4'($urandom);
      cdb_l_val    = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
